ocl_reg_master: RTL and testbench
=================================

OCL_REG_MASTER -- requirements
Module: ocl_reg_master
Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning cycles to wait for any slave handshake before aborting (1..65535).
REQ-002 SHALL have port clk_main_a0  in  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst_main  in  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_write  in  1  1 = register write, 0 = register read.
REQ-007 SHALL have port cmd_addr  in  32  register address.
REQ-008 SHALL have port cmd_wdata  in  32  write data.
REQ-009 SHALL have port rsp_valid  out  1  response available.
REQ-010 SHALL have port rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-011 SHALL have port rsp_rdata  out  32  read data; 0 for writes.
REQ-012 SHALL have port rsp_resp  out  2  slave BRESP/RRESP; 2'b11 on timeout.
REQ-013 SHALL have port awvalid  out  1  AXI-lite write address valid.
REQ-014 SHALL have port awready  in  1  write address ready.
REQ-015 SHALL have port awaddr  out  32  write address.
REQ-016 SHALL have port wvalid  out  1  write data valid.
REQ-017 SHALL have port wready  in  1  write data ready.
REQ-018 SHALL have port wdata  out  32  write data.
REQ-019 SHALL have port wstrb  out  4  byte strobes, constant 4'hF.
REQ-020 SHALL have port bvalid  in  1  write response valid.
REQ-021 SHALL have port bready  out  1  write response ready.
REQ-022 SHALL have port bresp  in  2  write response code.
REQ-023 SHALL have port arvalid  out  1  read address valid.
REQ-024 SHALL have port arready  in  1  read address ready.
REQ-025 SHALL have port araddr  out  32  read address.
REQ-026 SHALL have port rvalid  in  1  read data valid.
REQ-027 SHALL have port rready  out  1  read data ready.
REQ-028 SHALL have port rdata  in  32  read data.
REQ-029 SHALL have port rresp  in  2  read response code.
Function
REQ-030 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP; one transaction outstanding at a time.
REQ-031 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready, register addr/wdata and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0) next cycle.
REQ-032 WR_REQ: assert awvalid and wvalid together from the first cycle; each held, address/data stable, until its own ready is sampled high; AW and W may complete in the same or different cycles in either order; go to WR_RESP the cycle after both have completed.
REQ-033 WR_RESP: bready=1; on bvalid capture bresp, rsp_rdata=0, go to RSP.
REQ-034 RD_REQ: arvalid=1 held with stable araddr until arready; then RD_RESP with rready=1; on rvalid capture rdata/rresp, go to RSP.
REQ-035 bready/rready SHALL be 0 outside WR_RESP/RD_RESP; responses arriving there are ignored.
REQ-036 RSP: rsp_valid=1 with stable rsp_rdata/rsp_resp until rsp_ready; then IDLE; rsp_ready while rsp_valid=0 has no effect.
REQ-037 A 16-bit timeout counter SHALL clear on entering each of WR_REQ, WR_RESP, RD_REQ, RD_RESP and increment each cycle spent there; when it reaches TIMEOUT_CYC without the exit handshake, deassert all valids/readies, set rsp_resp=2'b11, rsp_rdata=0, go to RSP.
REQ-038 A handshake in the same cycle the count reaches TIMEOUT_CYC SHALL win over the timeout.
REQ-039 Latency with zero-wait slave: cmd accept to rsp_valid = 4 cycles (accept, REQ, RESP, RSP).
Reset
REQ-040 rst_main SHALL asynchronously force IDLE, counter 0, all outputs 0 except cmd_ready=1 and wstrb=4'hF, including mid-transaction.
Verification
REQ-041 Write 0x500 data 0xDEAD_BEEF, awready/wready/bvalid immediate, bresp 0 -> awaddr=0x500, wdata=0xDEADBEEF, rsp_valid 4 cycles after accept, rsp_resp=0, rsp_rdata=0.
REQ-042 Write with wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held; exactly one of each handshake.
REQ-043 Read 0x504, arready after 2 cycles, rdata 0x0000_0001, rresp 0 -> rsp_rdata=1, rsp_resp=0, araddr stable while waiting.
REQ-044 TIMEOUT_CYC=8, read with arready never asserted -> arvalid drops after 8 cycles, rsp_resp=2'b11, rsp_rdata=0.
REQ-045 rsp_ready held low 5 cycles with cmd_valid high -> rsp held, cmd_ready=0, next cmd accepted only after rsp_ready.
REQ-046 rst_main asserted during WR_RESP -> outputs reset same cycle, cmd_ready=1 after release.

Source files
------------

// File: rtl/ocl_reg_master.sv
// Single-outstanding AXI-lite register master: one command in, one AXI-lite
// read or write out, one response back, with a per-phase handshake timeout.
module ocl_reg_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_main_a0,
  input  logic        rst_main,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_aw_done, r_w_done;
  logic        r_cmd_ready, r_awvalid, r_wvalid, r_bready;
  logic        r_arvalid, r_rready, r_rsp_valid;
  logic [31:0] r_awaddr, r_wdata, r_araddr, r_rsp_rdata;
  logic [1:0]  r_rsp_resp;

  logic [15:0] w_cnt_inc;
  logic        w_tmo, w_aw_fin, w_w_fin;

  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_tmo     = (w_cnt_inc == TMO_LIMIT);
  // A channel counts as finished if it completed earlier or completes now.
  assign w_aw_fin  = r_aw_done | (r_awvalid & awready);
  assign w_w_fin   = r_w_done  | (r_wvalid  & wready);

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_araddr    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_cnt       <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          r_cnt <= w_cnt_inc;
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_cnt    <= '0;
            r_state  <= WR_RESP;
          end else if (w_tmo) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b11;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        WR_RESP: begin
          r_cnt <= w_cnt_inc;
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= bresp;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else if (w_tmo) begin
            r_bready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b11;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        RD_REQ: begin
          r_cnt <= w_cnt_inc;
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= RD_RESP;
          end else if (w_tmo) begin
            r_arvalid   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b11;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        RD_RESP: begin
          r_cnt <= w_cnt_inc;
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= rdata;
            r_rsp_resp  <= rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else if (w_tmo) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b11;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign awvalid   = r_awvalid;
  assign awaddr    = r_awaddr;
  assign wvalid    = r_wvalid;
  assign wdata     = r_wdata;
  assign wstrb     = 4'hF;
  assign bready    = r_bready;
  assign arvalid   = r_arvalid;
  assign araddr    = r_araddr;
  assign rready    = r_rready;

endmodule

// File: tb/tb_ocl_reg_master.sv
// Scoreboard bench for ocl_reg_master: directed commands against a delay-configurable
// AXI-lite slave model; a posedge monitor pops expected responses on rsp handshakes.
module tb_ocl_reg_master;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  ocl_reg_master #(.TIMEOUT_CYC(8)) dut (
    .clk_main_a0(clk_main_a0), .rst_main(rst_main),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", nm, act, exp, $time);
    end
  endtask

  // Slave model: each ready/valid rises after the master's valid/ready has been
  // high for dly cycles (0 = same cycle); dly < 0 means never.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic [31:0] s_rdata = '0;

  always @(negedge clk_main_a0) begin
    awready = awvalid && aw_dly >= 0 && aw_n >= aw_dly;
    wready  = wvalid  && w_dly  >= 0 && w_n  >= w_dly;
    bvalid  = bready  && b_dly  >= 0 && b_n  >= b_dly;
    arready = arvalid && ar_dly >= 0 && ar_n >= ar_dly;
    rvalid  = rready  && r_dly  >= 0 && r_n  >= r_dly;
    bresp = s_bresp; rresp = s_rresp; rdata = s_rdata;
    aw_n = awvalid ? aw_n + 1 : 0;
    w_n  = wvalid  ? w_n + 1  : 0;
    b_n  = bready  ? b_n + 1  : 0;
    ar_n = arvalid ? ar_n + 1 : 0;
    r_n  = rready  ? r_n + 1  : 0;
  end

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } exp_t;
  exp_t q[$];

  int cyc = 0, acc_cyc = 0, rsp_hs_cyc = 0, rsp_lat = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_awv = 0, n_wv = 0, n_arv = 0;
  logic [31:0] aw_hs_addr = '0, w_hs_data = '0, ar_hs_addr = '0, ar_first = '0;
  logic [3:0]  w_hs_strb = '0;
  logic [31:0] first_rdata = '0;
  logic [1:0]  first_resp = '0;
  bit rsp_seen = 0, ar_prev = 0;

  always @(posedge clk_main_a0) begin
    exp_t e;
    cyc++;
    if (rst_main) begin
      rsp_seen = 0;
      ar_prev = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (awvalid) n_awv++;
      if (wvalid) n_wv++;
      if (arvalid) n_arv++;
      if (awvalid && awready) begin n_aw++; aw_hs_addr = awaddr; end
      if (wvalid && wready) begin n_w++; w_hs_data = wdata; w_hs_strb = wstrb; end
      if (arvalid && !ar_prev) ar_first = araddr;
      ar_prev = arvalid;
      if (arvalid && arready) begin n_ar++; ar_hs_addr = araddr; end
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1;
        rsp_lat = cyc - acc_cyc;
        first_rdata = rsp_rdata;
        first_resp = rsp_resp;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_hs_cyc = cyc;
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h resp %0d expected none", rsp_rdata, rsp_resp);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          chk("rsp_rdata_held", first_rdata, e.rdata);
          chk("rsp_resp_held", 32'(first_resp), 32'(e.resp));
          if (e.lat >= 0) chk("rsp_latency", 32'(rsp_lat), 32'(e.lat));
        end
        rsp_seen = 0;
      end
    end
  end

  // Called at a negedge: sets the slave behaviour and clears per-test counters.
  task automatic cfg(input int aw, input int w, input int b, input int ar, input int r,
                     input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    s_bresp = br; s_rresp = rr; s_rdata = rd;
    n_aw = 0; n_w = 0; n_ar = 0; n_awv = 0; n_wv = 0; n_arv = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] e_rd, input logic [1:0] e_rs, input int lat, input bit push);
    exp_t e;
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    if (push) begin
      e.rdata = e_rd; e.resp = e_rs; e.lat = lat;
      q.push_back(e);
    end
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk_main_a0); n++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 expected 1");
    end
    @(posedge clk_main_a0);
    @(negedge clk_main_a0);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 200) begin @(negedge clk_main_a0); n++; end
    if (q.size() != 0 || rsp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_wait_timeout: %0d responses outstanding expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk_main_a0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wstrb", 32'(wstrb), 32'hF);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, rsp_valid, bready}, 32'd0);
    rst_main = 1'b0;
    @(negedge clk_main_a0);

    // Zero-wait write: accept, WR_REQ, WR_RESP, RSP -> rsp_valid 3 edges after accept.
    cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    send(1'b1, 32'h500, 32'hDEAD_BEEF, 32'h0, 2'b00, 3, 1);
    drain();
    chk("wr_awaddr", aw_hs_addr, 32'h500);
    chk("wr_wdata", w_hs_data, 32'hDEAD_BEEF);
    chk("wr_wstrb", 32'(w_hs_strb), 32'hF);
    chk("wr_hs_counts", {n_aw[15:0], n_w[15:0]}, {16'd1, 16'd1});

    // W completes first, AW on its 4th cycle; SLVERR passed through.
    @(negedge clk_main_a0);
    cfg(3, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0);
    send(1'b1, 32'h508, 32'h1234_5678, 32'h0, 2'b10, 6, 1);
    drain();
    chk("w_first_hs_counts", {n_aw[15:0], n_w[15:0]}, {16'd1, 16'd1});
    chk("w_first_wvalid_cyc", 32'(n_wv), 32'd1);
    chk("w_first_awvalid_cyc", 32'(n_awv), 32'd4);

    // AW completes first, W on its 3rd cycle.
    @(negedge clk_main_a0);
    cfg(0, 2, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    send(1'b1, 32'h50C, 32'h0BAD_F00D, 32'h0, 2'b00, 5, 1);
    drain();
    chk("aw_first_awvalid_cyc", 32'(n_awv), 32'd1);
    chk("aw_first_wvalid_cyc", 32'(n_wv), 32'd3);
    chk("aw_first_wdata", w_hs_data, 32'h0BAD_F00D);

    // Read with arready after 2 waiting cycles.
    @(negedge clk_main_a0);
    cfg(0, 0, 0, 2, 0, 2'b00, 2'b00, 32'h0000_0001);
    send(1'b0, 32'h504, 32'h0, 32'h0000_0001, 2'b00, 5, 1);
    drain();
    chk("rd_araddr", ar_hs_addr, 32'h504);
    chk("rd_araddr_first", ar_first, 32'h504);
    chk("rd_arvalid_cyc", 32'(n_arv), 32'd3);

    // arready never: abort after 8 cycles in RD_REQ.
    @(negedge clk_main_a0);
    cfg(0, 0, 0, -1, 0, 2'b00, 2'b00, 32'hFFFF_FFFF);
    send(1'b0, 32'h600, 32'h0, 32'h0, 2'b11, 9, 1);
    drain();
    chk("tmo_arvalid_cyc", 32'(n_arv), 32'd8);
    chk("tmo_ar_hs", 32'(n_ar), 32'd0);

    // arready on the 8th cycle: handshake beats the timeout.
    @(negedge clk_main_a0);
    cfg(0, 0, 0, 7, 0, 2'b00, 2'b01, 32'hCAFE_0001);
    send(1'b0, 32'h604, 32'h0, 32'hCAFE_0001, 2'b01, 10, 1);
    drain();
    chk("edge_ar_hs", 32'(n_ar), 32'd1);

    // bvalid never: abort after 8 cycles in WR_RESP.
    @(negedge clk_main_a0);
    cfg(0, 0, -1, 0, 0, 2'b00, 2'b00, 32'h0);
    send(1'b1, 32'h700, 32'h5555_AAAA, 32'h0, 2'b11, 10, 1);
    drain();
    chk("tmo_bready_low", 32'(bready), 32'd0);

    // Response backpressure with the next command already waiting.
    @(negedge clk_main_a0);
    cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_0077);
    rsp_ready = 1'b0;
    send(1'b1, 32'h510, 32'hA5A5_A5A5, 32'h0, 2'b00, 3, 1);
    fork
      send(1'b0, 32'h504, 32'h0, 32'h0000_0077, 2'b00, 3, 1);
      begin
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk_main_a0); n++; end
        repeat (5) begin
          chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
          chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
          @(negedge clk_main_a0);
        end
        rsp_ready = 1'b1;
      end
    join
    chk("next_cmd_after_rsp", 32'(acc_cyc - rsp_hs_cyc), 32'd1);
    drain();

    // Reset while waiting in WR_RESP.
    @(negedge clk_main_a0);
    cfg(0, 0, -1, 0, 0, 2'b00, 2'b00, 32'h0);
    send(1'b1, 32'h520, 32'h1111_2222, 32'h0, 2'b00, -1, 0);
    n = 0;
    while (!bready && n < 20) begin @(negedge clk_main_a0); n++; end
    chk("pre_rst_bready", 32'(bready), 32'd1);
    rst_main = 1'b1;
    #1;
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_outputs", {27'd0, awvalid, wvalid, arvalid, rsp_valid, bready}, 32'd0);
    chk("rst_mid_wstrb", 32'(wstrb), 32'hF);
    @(negedge clk_main_a0);
    rst_main = 1'b0;
    @(negedge clk_main_a0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_BEEF);
    send(1'b0, 32'h504, 32'h0, 32'h0000_BEEF, 2'b00, 3, 1);
    drain();

    repeat (2) @(negedge clk_main_a0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
